// File: rtl/int16_to_half_pipelined.sv
// rtl/int16_to_half_pipelined.sv - three-stage 16-bit integer to half-precision converter
module int16_to_half_pipelined (
    input  logic        clk,
    input  logic        reset,
    input  logic        in_Valid,
    input  logic        in_Signed,
    input  logic [16:1] in_Integer,
    output logic        out_Valid,
    output logic        out_Sign,
    output logic [5:1]  out_Exponent,
    output logic [10:1] out_Mantissa,
    output logic        SC_Inexact,
    output logic        SC_Output_OverFlow
);

    // Stage 1: sign / magnitude
    logic        s1_valid_q;
    logic        s1_sign_q,  s1_sign_d;
    logic        s1_zero_q,  s1_zero_d;
    logic [16:1] s1_mag_q,   s1_mag_d;

    always_comb begin
        s1_sign_d = in_Signed & in_Integer[16];
        s1_mag_d  = s1_sign_d ? (~in_Integer + 16'd1) : in_Integer;
        s1_zero_d = (in_Integer == 16'd0);
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            s1_valid_q <= 1'b0;
            s1_sign_q  <= 1'b0;
            s1_zero_q  <= 1'b0;
            s1_mag_q   <= 16'd0;
        end else begin
            s1_valid_q <= in_Valid;
            if (in_Valid) begin
                s1_sign_q <= s1_sign_d;
                s1_zero_q <= s1_zero_d;
                s1_mag_q  <= s1_mag_d;
            end
        end
    end

    // Stage 2: leading-one detect and normalise so the leading one lands on bit 16
    logic        s2_valid_q;
    logic        s2_sign_q;
    logic        s2_zero_q;
    logic [3:0]  s2_pos_q,   s2_pos_d;
    logic [16:1] s2_shift_q, s2_shift_d;

    always_comb begin
        s2_pos_d = 4'd0;
        for (int i = 1; i <= 16; i++) begin
            if (s1_mag_q[i]) begin
                s2_pos_d = 4'(i - 1);
            end
        end
        s2_shift_d = s1_mag_q << (4'd15 - s2_pos_d);
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            s2_valid_q <= 1'b0;
            s2_sign_q  <= 1'b0;
            s2_zero_q  <= 1'b0;
            s2_pos_q   <= 4'd0;
            s2_shift_q <= 16'd0;
        end else begin
            s2_valid_q <= s1_valid_q;
            if (s1_valid_q) begin
                s2_sign_q  <= s1_sign_q;
                s2_zero_q  <= s1_zero_q;
                s2_pos_q   <= s2_pos_d;
                s2_shift_q <= s2_shift_d;
            end
        end
    end

    // Stage 3: round to nearest even, pack, detect overflow
    logic        s3_valid_q;
    logic        s3_sign_q,  s3_sign_d;
    logic [5:1]  s3_exp_q,   s3_exp_d;
    logic [10:1] s3_mant_q,  s3_mant_d;
    logic        s3_inex_q,  s3_inex_d;
    logic        s3_ovf_q,   s3_ovf_d;

    logic        guard_bit;
    logic        sticky_bit;
    logic        round_up;
    logic [11:1] mant_sum;
    logic [6:1]  exp_sum;

    always_comb begin
        guard_bit  = s2_shift_q[5];
        sticky_bit = |s2_shift_q[4:1];
        round_up   = guard_bit & (sticky_bit | s2_shift_q[6]);
        mant_sum   = {1'b0, s2_shift_q[15:6]} + {10'd0, round_up};
        // A carry out of the mantissa leaves its low bits zero, so only the exponent needs bumping
        exp_sum    = 6'd15 + {2'b00, s2_pos_q} + {5'd0, mant_sum[11]};

        s3_sign_d = s2_sign_q;
        s3_exp_d  = exp_sum[5:1];
        s3_mant_d = mant_sum[10:1];
        s3_inex_d = guard_bit | sticky_bit;
        s3_ovf_d  = 1'b0;
        if (s2_zero_q) begin
            s3_sign_d = 1'b0;
            s3_exp_d  = 5'd0;
            s3_mant_d = 10'd0;
            s3_inex_d = 1'b0;
        end else if (exp_sum >= 6'd31) begin
            s3_exp_d  = 5'b11111;
            s3_mant_d = 10'd0;
            s3_ovf_d  = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            s3_valid_q <= 1'b0;
            s3_sign_q  <= 1'b0;
            s3_exp_q   <= 5'd0;
            s3_mant_q  <= 10'd0;
            s3_inex_q  <= 1'b0;
            s3_ovf_q   <= 1'b0;
        end else begin
            s3_valid_q <= s2_valid_q;
            if (s2_valid_q) begin
                s3_sign_q <= s3_sign_d;
                s3_exp_q  <= s3_exp_d;
                s3_mant_q <= s3_mant_d;
                s3_inex_q <= s3_inex_d;
                s3_ovf_q  <= s3_ovf_d;
            end
        end
    end

    assign out_Valid          = s3_valid_q;
    assign out_Sign           = s3_sign_q;
    assign out_Exponent       = s3_exp_q;
    assign out_Mantissa       = s3_mant_q;
    assign SC_Inexact         = s3_inex_q;
    assign SC_Output_OverFlow = s3_ovf_q;

endmodule
